// File: rtl/axis_mem_pkg.sv
// Shared definitions for the stream-memory family: burst engine state
// encoding and default geometry.
package axis_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  localparam int DEF_MEM_SIZE   = 4096;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry valid/ready buffer between the RAM read port and the stream
// output; exposes its occupancy so the producer can meter reads.
module axis_skid_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign m_valid = (count_q != 2'd0);
  assign s_ready = (count_q != 2'd2) || m_ready;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign m_data  = entry_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload registers are qualified by count, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: rtl/axis_burst_memory.sv
// Byte-strobed RAM with a command-driven burst reader streaming len+1 words
// onto an AXI-Stream style master with back-pressure and tlast.
module axis_burst_memory
  import axis_mem_pkg::*;
#(
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    s01_axis_aclk,
  input  logic                    s01_axis_areset,
  input  logic                    s01_axis_wr_en,
  input  logic [ADDR_WIDTH-1:0]   s01_axis_wr_addr,
  input  logic [DATA_WIDTH-1:0]   s01_axis_wr_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_wr_strb,
  input  logic                    s01_axis_cmd_valid,
  output logic                    s01_axis_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   s01_axis_cmd_addr,
  input  logic [LEN_WIDTH-1:0]    s01_axis_cmd_len,
  input  logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   s01_axis_rd_tdata,
  output logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  output logic                    s01_axis_tvalid,
  output logic                    s01_axis_tlast,
  output logic                    s01_axis_busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic                  clk;
  logic                  rst;
  burst_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] ram [MEM_SIZE];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH:0]    beats_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  accept;
  logic                  issue;
  logic                  last_xfer;
  logic [2:0]            occupancy;
  logic                  fifo_s_ready;
  logic                  fifo_m_valid;
  logic [DATA_WIDTH:0]   fifo_m_data;
  logic [1:0]            fifo_count;
  logic                  fifo_pop;

  assign clk = s01_axis_aclk;
  assign rst = s01_axis_areset;

  assign accept     = s01_axis_cmd_valid && s01_axis_cmd_ready;
  assign start_addr = ({1'b0, s01_axis_cmd_addr} < SIZE_EXT) ? s01_axis_cmd_addr : '0;
  assign fifo_pop   = fifo_m_valid && s01_axis_tready;
  assign last_xfer  = fifo_pop && fifo_m_data[DATA_WIDTH];

  // Credit the beat leaving this cycle so a full-rate stream never bubbles.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_valid_q} - {2'b00, fifo_pop};
  assign issue     = (state_q == BURST) && (beats_q != '0) && fifo_s_ready &&
                     (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    s01_axis_cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        s01_axis_cmd_ready = 1'b1;
        if (s01_axis_cmd_valid) state_d = BURST;
      end
      BURST: begin
        if (last_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      beats_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= issue;
      if (accept) begin
        addr_q  <= start_addr;
        beats_q <= {1'b0, s01_axis_cmd_len} + (LEN_WIDTH + 1)'(1);
      end else if (issue) begin
        addr_q    <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        beats_q   <= beats_q - 1'b1;
        rd_last_q <= (beats_q == (LEN_WIDTH + 1)'(1));
      end
    end
  end

  // NOTE: the RAM has no reset (contents survive reset), and because the read
  // and write both use non-blocking updates, a same-address collision reads
  // the old word.
  always_ff @(posedge clk) begin
    if (s01_axis_wr_en && ({1'b0, s01_axis_wr_addr} < SIZE_EXT)) begin
      for (int b = 0; b < NB; b++) begin
        if (s01_axis_wr_strb[b])
          ram[s01_axis_wr_addr][b*8 +: 8] <= s01_axis_wr_tdata[b*8 +: 8];
      end
    end
    if (issue) rd_data_q <= ram[addr_q];
  end

  axis_skid_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .s_valid (rd_valid_q),
    .s_ready (fifo_s_ready),
    .s_data  ({rd_last_q, rd_data_q}),
    .m_valid (fifo_m_valid),
    .m_ready (s01_axis_tready),
    .m_data  (fifo_m_data),
    .count   (fifo_count)
  );

  assign s01_axis_tvalid   = fifo_m_valid;
  assign s01_axis_rd_tdata = fifo_m_valid ? fifo_m_data[DATA_WIDTH-1:0] : '0;
  assign s01_axis_tlast    = fifo_m_valid && fifo_m_data[DATA_WIDTH];
  assign s01_axis_tstrb    = {NB{fifo_m_valid}};
  assign s01_axis_busy     = (state_q == BURST) || rd_valid_q || fifo_m_valid;

endmodule

// File: tb/tb_axis_burst_memory.sv
// Directed and randomized bench for axis_burst_memory against a word-array
// reference model of the memory and the stream timing rules.
module tb_axis_burst_memory;

  localparam int MEM_SIZE = 4096;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_tdata;
  logic [3:0]    wr_strb;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          tready;
  logic [DW-1:0] rd_tdata;
  logic [3:0]    tstrb;
  logic          tvalid;
  logic          tlast;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_mem [MEM_SIZE];

  always #5 clk = ~clk;

  axis_burst_memory #(
    .MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .s01_axis_aclk      (clk),
    .s01_axis_areset    (areset),
    .s01_axis_wr_en     (wr_en),
    .s01_axis_wr_addr   (wr_addr),
    .s01_axis_wr_tdata  (wr_tdata),
    .s01_axis_wr_strb   (wr_strb),
    .s01_axis_cmd_valid (cmd_valid),
    .s01_axis_cmd_ready (cmd_ready),
    .s01_axis_cmd_addr  (cmd_addr),
    .s01_axis_cmd_len   (cmd_len),
    .s01_axis_tready    (tready),
    .s01_axis_rd_tdata  (rd_tdata),
    .s01_axis_tstrb     (tstrb),
    .s01_axis_tvalid    (tvalid),
    .s01_axis_tlast     (tlast),
    .s01_axis_busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    wr_en = 1'b1; wr_addr = AW'(a); wr_tdata = d; wr_strb = s;
    step();
    wr_en = 1'b0;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model_mem[a] = (model_mem[a] & ~mask) | (d & mask);
  endtask

  function automatic int tready_pattern(input int mode, input int cyc);
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    if (mode == 0) return 1;
    if (mode == 1) return pat[cyc % 6];
    return int'($urandom_range(0, 1));
  endfunction

  // Drains one burst from the third edge after accept onwards.
  task automatic collect(input logic [31:0] exp_q[$], input int mode);
    int n = exp_q.size();
    int beat = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held_data = '0;
    logic held_last = 1'b0;
    logic r;
    while (beat < n && cyc < 8 * n + 20) begin
      check("tvalid_continuous", tvalid, 1);
      if (stalled) begin
        check("stall_hold_data", rd_tdata, held_data);
        check("stall_hold_last", tlast, held_last);
      end
      r = tready_pattern(mode, cyc) != 0;
      tready = r;
      if (tvalid && r) begin
        check("beat_data", rd_tdata, exp_q[beat]);
        check("beat_last", tlast, beat == n - 1);
        check("beat_strb", tstrb, 4'hF);
        beat++;
        stalled = 1'b0;
      end else if (tvalid) begin
        stalled = 1'b1;
        held_data = rd_tdata;
        held_last = tlast;
      end
      step();
      cyc++;
    end
    tready = 1'b0;
    check("beats_received", beat, n);
    check("post_tvalid", tvalid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
  endtask

  task automatic send_cmd(input int a, input int len);
    cmd_valid = 1'b1; cmd_addr = AW'(a); cmd_len = LW'(len);
    check("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("accept_cmd_ready", cmd_ready, 0);
    check("accept_tvalid", tvalid, 0);
    check("accept_busy", busy, 1);
    step();
  endtask

  task automatic run_burst(input int a, input int len, input int mode);
    logic [31:0] exp_q[$];
    for (int i = 0; i <= len; i++) exp_q.push_back(model_mem[(a + i) % MEM_SIZE]);
    tready = (mode == 0);
    send_cmd(a, len);
    check("latency_tvalid_t1", tvalid, 0);
    step();
    collect(exp_q, mode);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int a, len;
    areset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_tdata = '0; wr_strb = '0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; tready = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = '0;
    step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tstrb", tstrb, 0);
    check("rst_rd_tdata", rd_tdata, 0);
    check("rst_busy", busy, 0);
    areset = 1'b0;
    step();

    // Byte strobes: merged word 0xAA22CC44 from a single-beat burst.
    write_word(5, 32'hAABBCCDD, 4'b1111);
    write_word(5, 32'h11223344, 4'b0101);
    check("strobe_model", model_mem[5], 32'hAA22CC44);
    run_burst(5, 0, 0);

    // Full-rate and back-pressured bursts over 0..15.
    for (int i = 0; i < 16; i++) write_word(i, i, 4'hF);
    run_burst(0, 15, 0);
    run_burst(0, 15, 1);

    // Wrap from the top of memory to address 0.
    write_word(4094, 32'hCAFE0FFE, 4'hF);
    write_word(4095, 32'h0BADF00D, 4'hF);
    run_burst(4094, 3, 0);

    for (int i = 16; i < 64; i++) write_word(i, $urandom, 4'hF);

    // Collision: beat 1 (address 21) is read on the third edge after accept.
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[20 + i]);
    tready = 1'b1;
    send_cmd(20, 3);
    wr_en = 1'b1; wr_addr = AW'(21); wr_tdata = 32'hDEADBEEF; wr_strb = 4'hF;
    step();
    wr_en = 1'b0;
    model_mem[21] = 32'hDEADBEEF;
    collect(exp_q, 0);
    run_burst(21, 0, 0);
    check("collision_model", model_mem[21], 32'hDEADBEEF);

    // Reset while beat 3 of an 8-beat burst is presented.
    tready = 1'b1;
    send_cmd(30, 7);
    step();
    for (int i = 0; i < 3; i++) begin
      check("prereset_beat", rd_tdata, model_mem[30 + i]);
      step();
    end
    check("prereset_beat3_valid", tvalid, 1);
    areset = 1'b1; tready = 1'b0;
    step();
    areset = 1'b0;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_tlast", tlast, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    step();
    check("midrst_idle_tvalid", tvalid, 0);
    run_burst(30, 7, 0);

    // Random writes interleaved with random bursts under random back-pressure.
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        write_word(int'($urandom_range(0, 63)), $urandom, 4'($urandom));
      a = int'($urandom_range(0, 63));
      len = int'($urandom_range(0, (63 - a) < 20 ? (63 - a) : 20));
      run_burst(a, len, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
